rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Owns the single register-file write port (A3/WD3/WE3) and shares it between NREQ writeback requesters.
//  Requesters include the ALU result, the load result and the CSR/misc path.
//  After reset, sequences an INIT sweep that writes INIT_VAL to every register.
//  Then grants one valid/ready request per cycle, round-robin.
//  Output is registered and drives register_file write inputs directly.
// PARAMETERS
//  NREQ      3   number of writeback requesters (2..8)
//  NUM_REGS  32  registers swept during INIT (power of 2, matches file depth)
//  AW        5   address width, = log2(NUM_REGS)
//  DW        32  data width
//  INIT_VAL  0   value written to every register during INIT
//  DROP_X0   1   1: accepted writes to address 0 complete handshake but never assert rf_we
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        asynchronous, active-high reset
//  req_valid  in   NREQ     requester i has a write pending
//  req_addr   in   NREQ*AW  dest address, slice i = [i*AW +: AW]
//  req_data   in   NREQ*DW  write data, slice i = [i*DW +: DW]
//  req_ready  out  NREQ     one-hot/zero; transfer i when req_valid[i] & req_ready[i]
//  rf_we      out  1        to register_file WE3
//  rf_waddr   out  AW       to register_file A3
//  rf_wdata   out  DW       to register_file WD3
//  init_done  out  1        high once INIT sweep finished; stays high until next reset
//  busy       out  1        high while INIT, or while a rf write is being presented
// BEHAVIOUR
//  Reset (async, any time incl. mid-sweep or mid-transfer):
//   state=INIT, sweep_cnt=0, rr_ptr=0, rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0; req_ready=0 while in reset.
//  FSM INIT:
//   - Each cycle registers rf_we=1, rf_waddr=sweep_cnt, rf_wdata=INIT_VAL, then sweep_cnt++.
//   - DROP_X0 does not apply; address 0 is written too.
//   - req_ready=0 throughout.
//   - After presenting address NUM_REGS-1 (NUM_REGS cycles): go to ARB, init_done=1 next cycle.
//   - sweep_cnt never wraps.
//  FSM ARB:
//   - Grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//   - req_ready[grant]=1 combinationally in the same cycle; all other ready bits are 0.
//   - No valid -> req_ready=0, rr_ptr unchanged.
//   - On transfer of i: rr_ptr <= (i+1) mod NREQ.
//   - On transfer of i, next cycle: rf_we <= !(DROP_X0 && addr==0), rf_waddr <= addr, rf_wdata <= data.
//   - No transfer -> rf_we <= 0; rf_waddr/rf_wdata hold their last values.
//   - Latency is exactly 1 cycle, accept to rf_we. Throughput is 1 write/cycle; no stall source in ARB.
//   - ARB is terminal until reset.
//  Simultaneous valids: exactly one granted per cycle; others wait.
//   - A requester must hold valid/addr/data stable until accepted.
//   - Starvation bound: NREQ-1 cycles.
//  req_ready may depend on req_valid of any requester. Requesters must not gate valid on ready.
//  busy = (state==INIT) | rf_we.
//  Read-after-write forwarding is not provided; register_file read is async, so data is visible the cycle after rf_we.
// STRUCTURE
//  Package rf_ctrl_pkg:
//   - localparams RF_AW=5, RF_DW=32, RF_NUM_REGS=32.
//   - typedef enum logic [0:0] {ST_INIT, ST_ARB} rf_arb_state_t.
//   - typedef struct packed {logic we; logic [RF_AW-1:0] addr; logic [RF_DW-1:0] data;} rf_wr_t.
//  Sub-module rr_arbiter (NREQ; req, ptr -> one-hot gnt, gnt_idx) is pure combinational and reusable for the read-port scheduler.
//  FSM, sweep counter, rr_ptr and output register stay in this module.
// TESTING (bench instantiates rf_write_arbiter + register_file, NREQ=3)
//  1. Reset, idle 40 cycles:
//     - rf_we high exactly cycles 1..32, addr 0..31, data 0; init_done rises at cycle 33.
//     - All 32 RF regs read 0; req_ready stays 0 while INIT.
//  2. After init, req0 writes {addr=5, data=32'hDEADBEEF}:
//     - req_ready[0] same cycle; next cycle rf_we=1, addr=5.
//     - RD1(A1=5)=32'hDEADBEEF the cycle after.
//  3. All three valid continuously, addr 1/2/3, rr_ptr=0:
//     - Grants 0,1,2,0,1,2; rf_waddr sequence 1,2,3,1,2,3.
//     - Never two ready bits high together.
//  4. req1 writes {addr=0, data=7} with DROP_X0=1:
//     - Handshake completes, rf_we stays 0, reg0 still 0.
//     - Rerun with DROP_X0=0: reg0=7.
//  5. Assert rst at INIT cycle 10, release:
//     - rf_we=0 immediately (async), sweep restarts at addr 0.
//  6. Assert rst in ARB with req2 valid:
//     - Outputs zero immediately, no write issued, init_done=0, full INIT repeats.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types and default geometry for the register-file control blocks.
package rf_ctrl_pkg;

    localparam int RF_AW       = 5;
    localparam int RF_DW       = 32;
    localparam int RF_NUM_REGS = 32;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_ARB
    } rf_arb_state_t;

    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping mod N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    localparam int unsigned NU = N;

    int unsigned j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < NU; k++) begin
            j = (32'(ptr) + k) % NU;
            if (!any && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = PW'(j);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: INIT sweep after reset, then round-robin writeback arbitration.
module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int              NREQ     = 3,
    parameter int              NUM_REGS = RF_NUM_REGS,
    parameter int              AW       = RF_AW,
    parameter int              DW       = RF_DW,
    parameter logic [DW-1:0]   INIT_VAL = '0,
    parameter bit              DROP_X0  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic                 init_done,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);

    rf_arb_state_t   state;
    rf_arb_state_t   state_next;
    logic [AW-1:0]   sweep_cnt;
    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            last_sweep;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign last_sweep = (sweep_cnt == AW'(NUM_REGS - 1));
    assign xfer       = (state == ST_ARB) && gnt_any;
    // Gate on rst as well so ready is low for the whole reset pulse, not just after the first edge.
    assign req_ready  = ((state == ST_ARB) && !rst) ? gnt : '0;
    assign busy       = (state == ST_INIT) | rf_we;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_INIT: if (last_sweep) state_next = ST_ARB;
            ST_ARB:  state_next = ST_ARB;
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt <= '0;
            rr_ptr    <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            rf_we    <= 1'b1;
            rf_waddr <= sweep_cnt;
            rf_wdata <= INIT_VAL;
            if (!last_sweep) sweep_cnt <= sweep_cnt + 1'b1;
        end else begin
            init_done <= 1'b1;
            rf_we     <= xfer && !(DROP_X0 && (sel_addr == '0));
            if (xfer) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                rr_ptr   <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench: INIT sweep, round-robin table, x0 drop and asynchronous reset corners.
module tb_rf_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready, req_ready_nx;
    logic                rf_we, rf_we_nx;
    logic [AW-1:0]       rf_waddr, rf_waddr_nx;
    logic [DW-1:0]       rf_wdata, rf_wdata_nx;
    logic                init_done, init_done_nx;
    logic                busy, busy_nx;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .NREQ(NREQ), .NUM_REGS(32), .AW(AW), .DW(DW), .INIT_VAL(32'h0), .DROP_X0(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .init_done(init_done), .busy(busy)
    );

    rf_write_arbiter #(
        .NREQ(NREQ), .NUM_REGS(32), .AW(AW), .DW(DW), .INIT_VAL(32'h0), .DROP_X0(1'b0)
    ) dut_nx (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready_nx), .rf_we(rf_we_nx), .rf_waddr(rf_waddr_nx), .rf_wdata(rf_wdata_nx),
        .init_done(init_done_nx), .busy(busy_nx)
    );

    // Register-file stand-ins fed by each arbiter's write port.
    logic        mem_fill;
    logic [31:0] mem    [32];
    logic [31:0] mem_nx [32];

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int r = 0; r < 32; r++) begin
                mem[r]    <= 32'hA5A5A5A5;
                mem_nx[r] <= 32'hA5A5A5A5;
            end
        end else begin
            if (rf_we)    mem[rf_waddr]       <= rf_wdata;
            if (rf_we_nx) mem_nx[rf_waddr_nx] <= rf_wdata_nx;
        end
    end

    typedef struct packed {
        logic [2:0]       valid;
        logic [2:0][4:0]  addr;
        logic [2:0][31:0] data;
        logic [2:0]       exp_ready;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t sb[$];
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    vec_t vecs[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] v,
                                 input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [2:0] er);
        vec_t t;
        t.valid = v;
        t.addr[0] = a0; t.addr[1] = a1; t.addr[2] = a2;
        t.data[0] = d0; t.data[1] = d1; t.data[2] = d2;
        t.exp_ready = er;
        return t;
    endfunction

    // Called right after rst is released on a negedge; cycle n is the interval after edge n.
    task automatic init_run(input int ncyc);
        req_valid = '1;
        req_addr  = {5'd7, 5'd6, 5'd0};
        req_data  = {32'h3, 32'h2, 32'h1};
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk); #1;
            chk("init_we", 64'(rf_we), 64'(n <= 32));
            if (n <= 32) begin
                chk("init_addr", 64'(rf_waddr), 64'(n - 1));
                chk("init_data", 64'(rf_wdata), 64'(0));
            end
            chk("init_done", 64'(init_done), 64'(n >= 33));
            chk("init_busy", 64'(busy), 64'(n <= 32));
            if (n <= 31) chk("init_ready", 64'(req_ready), 64'(0));
            if (n == 31) req_valid = '0;
        end
    endtask

    task automatic cyc(input vec_t v);
        wr_t e;
        req_valid = v.valid;
        req_addr  = v.addr;
        req_data  = v.data;
        #1;
        chk("ready", 64'(req_ready), 64'(v.exp_ready));
        chk("ready_onehot0", 64'($onehot0(req_ready)), 64'(1));
        for (int i = 0; i < NREQ; i++) begin
            if (v.exp_ready[i]) begin
                last_addr = v.addr[i];
                last_data = v.data[i];
            end
        end
        e.we   = (v.exp_ready != 3'b000) && (last_addr != 5'd0);
        e.addr = last_addr;
        e.data = last_data;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("wr_we", 64'(rf_we), 64'(e.we));
        chk("wr_addr", 64'(rf_waddr), 64'(e.addr));
        chk("wr_data", 64'(rf_wdata), 64'(e.data));
        chk("wr_busy", 64'(busy), 64'(e.we));
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = mkv(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b001);
        vecs[1]  = mkv(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);
        vecs[2]  = mkv(3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h9, 3'b100);
        vecs[3]  = mkv(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001);
        vecs[4]  = mkv(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010);
        vecs[5]  = mkv(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100);
        vecs[6]  = mkv(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001);
        vecs[7]  = mkv(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010);
        vecs[8]  = mkv(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100);
        vecs[9]  = mkv(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h7, 32'h0, 3'b010);
        vecs[10] = mkv(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);
        vecs[11] = mkv(3'b101, 5'd12, 5'd0, 5'd13, 32'hC0, 32'h0, 32'hD0, 3'b100);
        vecs[12] = mkv(3'b101, 5'd12, 5'd0, 5'd14, 32'hC0, 32'h0, 32'hE0, 3'b001);
        vecs[13] = mkv(3'b101, 5'd15, 5'd0, 5'd14, 32'hF0, 32'h0, 32'hE0, 3'b100);
        vecs[14] = mkv(3'b001, 5'd15, 5'd0, 5'd0, 32'hF0, 32'h0, 32'h0, 3'b001);
        vecs[15] = mkv(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);

        rst = 1'b1; mem_fill = 1'b1;
        req_valid = '0; req_addr = '0; req_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_we", 64'(rf_we), 64'(0));
        mem_fill = 1'b0;
        rst = 1'b0;

        // Test 1: INIT sweep from reset
        init_run(40);
        for (int r = 0; r < 32; r++) begin
            chk("init_mem", 64'(mem[r]), 64'(0));
            chk("init_mem_nx", 64'(mem_nx[r]), 64'(0));
        end
        chk("init_done_nx", 64'(init_done_nx), 64'(1));

        // Tests 2-4: arbitration table
        last_addr = 5'd31;
        last_data = 32'h0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            cyc(vecs[k]);
            if (k == 1) chk("rd_after_wr5", 64'(mem[5]), 64'(32'hDEADBEEF));
        end
        chk("sb_empty", 64'(sb.size()), 64'(0));
        chk("mem5", 64'(mem[5]), 64'(32'hDEADBEEF));
        chk("mem9", 64'(mem[9]), 64'(32'h9));
        chk("mem1", 64'(mem[1]), 64'(32'h11));
        chk("mem2", 64'(mem[2]), 64'(32'h22));
        chk("mem3", 64'(mem[3]), 64'(32'h33));
        chk("mem12", 64'(mem[12]), 64'(32'hC0));
        chk("mem13", 64'(mem[13]), 64'(32'hD0));
        chk("mem14", 64'(mem[14]), 64'(32'hE0));
        chk("mem15", 64'(mem[15]), 64'(32'hF0));
        chk("x0_dropped", 64'(mem[0]), 64'(0));
        chk("x0_kept_nx", 64'(mem_nx[0]), 64'(7));

        // Test 5: reset in the middle of INIT
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        init_run(10);
        rst = 1'b1;
        #1;
        chk("midinit_we", 64'(rf_we), 64'(0));
        chk("midinit_addr", 64'(rf_waddr), 64'(0));
        chk("midinit_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        init_run(40);
        chk("reinit_mem5", 64'(mem[5]), 64'(0));

        // Test 6: reset in ARB with a pending request
        @(negedge clk);
        req_valid = 3'b100;
        req_addr  = {5'd4, 5'd0, 5'd0};
        req_data  = {32'h44, 32'h0, 32'h0};
        #1;
        chk("arb_ready2", 64'(req_ready), 64'(3'b100));
        rst = 1'b1;
        #1;
        chk("arbrst_ready", 64'(req_ready), 64'(0));
        chk("arbrst_we", 64'(rf_we), 64'(0));
        chk("arbrst_wdata", 64'(rf_wdata), 64'(0));
        chk("arbrst_done", 64'(init_done), 64'(0));
        @(posedge clk); #1;
        chk("arbrst_nowrite", 64'(rf_we), 64'(0));
        chk("arbrst_mem4", 64'(mem[4]), 64'(0));
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        init_run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
